fb_arbiter: RTL and testbench

Arbitrates the single-port framebuffer BRAM, in the gpu_clk domain, between three requesters: the VGA scanout line prefetcher, the CPU I/O-register pixel port, and the draw engine.
- Scanout has fixed top priority, bounded by a starvation guard.
- CPU and draw engine share the remaining slots round-robin.
- Returns read data to the requester that issued the read, using a latency-matched tag pipeline.

---
 rtl/gpu_pkg.sv | 14 +
 rtl/fb_rd_tag_pipe.sv | 37 +++
 rtl/fb_arbiter.sv | 140 ++++++++++++++
 tb/tb_fb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared framebuffer widths and requester identifiers for the GPU clock domain.
package gpu_pkg;

  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 12;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_SCAN = 2'd1,
    REQ_CPU  = 2'd2,
    REQ_DRAW = 2'd3
  } req_id_t;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Read-return tag pipeline: carries {valid, id} alongside the BRAM read latency
// so returned data can be steered to the requester that issued the read.
module fb_rd_tag_pipe
  import gpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  req_id_t i_id,
  output logic    o_valid,
  output req_id_t o_id
);

  logic [DEPTH-1:0] r_valid;
  req_id_t          r_id [DEPTH];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_id[i] <= REQ_NONE;
    end else begin
      r_valid[0] <= i_valid;
      r_id[0]    <= i_id;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_id[i]    <= r_id[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer BRAM arbiter: scanout has priority (with a starvation
// guard), CPU and draw engine share the remaining slots round-robin.
module fb_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              gpu_clk,
  input  logic              reset,
  input  logic              so_req,
  input  logic [ADDR_W-1:0] so_addr,
  output logic              so_gnt,
  output logic              so_rvalid,
  output logic [DATA_W-1:0] so_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dr_req,
  input  logic [ADDR_W-1:0] dr_addr,
  input  logic [DATA_W-1:0] dr_wdata,
  output logic              dr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  req_id_t           r_rr_ptr;
  logic [7:0]        r_starve_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  req_id_t           r_mem_id;
  logic [DATA_W-1:0] r_so_rdata;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic    w_lo_pending;
  logic    w_lo_cpu;
  logic    w_starved;
  logic    w_so_win;
  logic    w_tag_valid;
  req_id_t w_tag_id;

  assign w_lo_pending = cpu_req | dr_req;
  // CPU wins the low-priority slot if alone, or if both pend and it is CPU's turn.
  assign w_lo_cpu     = cpu_req & (~dr_req | (r_rr_ptr == REQ_CPU));
  assign w_starved    = w_lo_pending & (r_starve_cnt == LIMIT);
  assign w_so_win     = so_req & ~w_starved;

  assign so_gnt  = ~reset & w_so_win;
  assign cpu_gnt = ~reset & ~w_so_win & w_lo_cpu;
  assign dr_gnt  = ~reset & ~w_so_win & w_lo_pending & ~w_lo_cpu;

  // Round-robin pointer and scanout starvation counter.
  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      r_rr_ptr     <= REQ_CPU;
      r_starve_cnt <= '0;
    end else begin
      if (cpu_gnt) r_rr_ptr <= REQ_DRAW;
      else if (dr_gnt) r_rr_ptr <= REQ_CPU;

      if (cpu_gnt || dr_gnt || !w_lo_pending) r_starve_cnt <= '0;
      else if (so_gnt && r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // Register the granted command onto the BRAM port one cycle after the grant.
  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_id    <= REQ_NONE;
    end else begin
      r_mem_en <= so_gnt | cpu_gnt | dr_gnt;
      r_mem_we <= 1'b0;
      if (so_gnt) begin
        r_mem_addr  <= so_addr;
        r_mem_wdata <= '0;
        r_mem_id    <= REQ_SCAN;
      end else if (cpu_gnt) begin
        r_mem_we    <= cpu_we;
        r_mem_addr  <= cpu_addr;
        r_mem_wdata <= cpu_wdata;
        r_mem_id    <= REQ_CPU;
      end else if (dr_gnt) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= dr_addr;
        r_mem_wdata <= dr_wdata;
        r_mem_id    <= REQ_DRAW;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Only reads leave a tag; it pops out exactly when mem_rdata is valid.
  fb_rd_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
    .clk     (gpu_clk),
    .rst     (reset),
    .i_valid (r_mem_en & ~r_mem_we),
    .i_id    (r_mem_id),
    .o_valid (w_tag_valid),
    .o_id    (w_tag_id)
  );

  assign so_rvalid  = w_tag_valid & (w_tag_id == REQ_SCAN);
  assign cpu_rvalid = w_tag_valid & (w_tag_id == REQ_CPU);

  // Hold the last returned word per requester between returns.
  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      r_so_rdata  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      if (so_rvalid)  r_so_rdata  <= mem_rdata;
      if (cpu_rvalid) r_cpu_rdata <= mem_rdata;
    end
  end

  assign so_rdata  = so_rvalid  ? mem_rdata : r_so_rdata;
  assign cpu_rdata = cpu_rvalid ? mem_rdata : r_cpu_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter with a BRAM model (latency 2).
module tb_fb_arbiter;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int LAT = 2;
  localparam int LIM = 8;

  logic          gpu_clk = 1'b0;
  logic          reset = 1'b1;
  logic          so_req = 1'b0;
  logic [AW-1:0] so_addr = '0;
  logic          so_gnt, so_rvalid;
  logic [DW-1:0] so_rdata;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dr_req = 1'b0;
  logic [AW-1:0] dr_addr = '0;
  logic [DW-1:0] dr_wdata = '0;
  logic          dr_gnt;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 gpu_clk = ~gpu_clk;

  fb_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .gpu_clk(gpu_clk), .reset(reset),
    .so_req(so_req), .so_addr(so_addr), .so_gnt(so_gnt),
    .so_rvalid(so_rvalid), .so_rdata(so_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_wdata(dr_wdata), .dr_gnt(dr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // BRAM model: 256 words, read data appears LAT cycles after mem_en.
  logic [DW-1:0] bram [0:255];
  logic [DW-1:0] rd_pipe [0:LAT-1];
  logic          bram_init = 1'b0;

  always @(posedge gpu_clk) begin
    if (!bram_init) begin
      for (int i = 0; i < 256; i++) bram[i] <= '0;
      for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
      bram_init <= 1'b1;
    end else begin
      if (mem_en && mem_we) bram[mem_addr[7:0]] <= mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? bram[mem_addr[7:0]] : 12'h000;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] d;
  } ret_t;

  task automatic do_reset();
    @(negedge gpu_clk);
    reset = 1'b1;
    so_req = 1'b0; cpu_req = 1'b0; dr_req = 1'b0;
    repeat (2) @(negedge gpu_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    so_req = 1'b1; cpu_req = 1'b1; dr_req = 1'b1;
    repeat (2) @(negedge gpu_clk);
    checks++; if ({so_gnt, cpu_gnt, dr_gnt} !== 3'b000) begin errors++;
      $display("FAIL reset_gnt: got %b want 000", {so_gnt, cpu_gnt, dr_gnt}); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++;
      $display("FAIL reset_mem_ctl: got %b want 00", {mem_en, mem_we}); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++;
      $display("FAIL reset_mem_data: addr %h wdata %h want 0", mem_addr, mem_wdata); end
    checks++; if ({so_rvalid, cpu_rvalid} !== 2'b00 || so_rdata !== '0 || cpu_rdata !== '0) begin errors++;
      $display("FAIL reset_rd: rv %b so %h cpu %h want 0", {so_rvalid, cpu_rvalid}, so_rdata, cpu_rdata); end
    so_req = 1'b0; cpu_req = 1'b0; dr_req = 1'b0;
    @(negedge gpu_clk);
    reset = 1'b0;
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00010; cpu_wdata = 12'hF00;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || so_gnt !== 1'b0 || dr_gnt !== 1'b0) begin errors++;
      $display("FAIL wr_gnt: got %b want 010", {so_gnt, cpu_gnt, dr_gnt}); end
    @(negedge gpu_clk);
    cpu_req = 1'b0;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'h00010 || mem_wdata !== 12'hF00) begin
      errors++; $display("FAIL wr_cmd: en %b we %b addr %h wd %h want 1 1 00010 f00",
                         mem_en, mem_we, mem_addr, mem_wdata); end
    for (int k = 0; k < 4; k++) begin
      @(negedge gpu_clk);
      checks++; if (cpu_rvalid !== 1'b0 || so_rvalid !== 1'b0) begin errors++;
        $display("FAIL wr_no_rvalid: cycle %0d got %b want 00", k, {so_rvalid, cpu_rvalid}); end
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++;
      $display("FAIL rd_gnt: got %b want 1", cpu_gnt); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge gpu_clk);
      cpu_req = 1'b0;
      checks++; if (cpu_rvalid !== (k == 3) || so_rvalid !== 1'b0) begin errors++;
        $display("FAIL rd_rvalid: T+%0d cpu %b so %b want %b 0", k, cpu_rvalid, so_rvalid, k == 3); end
      if (k >= 3) begin
        checks++; if (cpu_rdata !== 12'hF00) begin errors++;
          $display("FAIL rd_data: T+%0d got %h want f00", k, cpu_rdata); end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00020; cpu_wdata = 12'h0A0;
    dr_req = 1'b1; dr_addr = 19'h00021; dr_wdata = 12'h00B;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge gpu_clk);
      #1;
      checks++; if (cpu_gnt !== (i % 2 == 0) || dr_gnt !== (i % 2 == 1) || so_gnt !== 1'b0) begin
        errors++; $display("FAIL rr: cycle %0d got s/c/d %b want cpu=%b", i,
                           {so_gnt, cpu_gnt, dr_gnt}, i % 2 == 0); end
    end
    @(negedge gpu_clk);
    cpu_req = 1'b0; dr_req = 1'b0;
  endtask

  task automatic test_starvation();
    do_reset();
    so_req = 1'b1; so_addr = 19'(($urandom % 16));
    dr_req = 1'b1; dr_addr = 19'h00030; dr_wdata = 12'h123;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge gpu_clk);
      if (i == 9) dr_req = 1'b0;
      #1;
      checks++; if (so_gnt !== (i != 8) || dr_gnt !== (i == 8) || cpu_gnt !== 1'b0) begin
        errors++; $display("FAIL starve: cycle %0d got s/c/d %b want so=%b", i,
                           {so_gnt, cpu_gnt, dr_gnt}, i != 8); end
    end
    @(negedge gpu_clk);
    so_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [0:3];
    do_reset();
    for (int a = 0; a < 4; a++) begin
      vals[a] = DW'($urandom);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'(a); cpu_wdata = vals[a];
      #1;
      checks++; if (cpu_gnt !== 1'b1) begin errors++;
        $display("FAIL b2b_wr_gnt: addr %0d got %b want 1", a, cpu_gnt); end
      @(negedge gpu_clk);
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 4) begin so_req = 1'b1; so_addr = 19'(i); end
      else so_req = 1'b0;
      #1;
      if (i < 4) begin
        checks++; if (so_gnt !== 1'b1) begin errors++;
          $display("FAIL b2b_gnt: cycle %0d got %b want 1", i, so_gnt); end
      end
      checks++; if (so_rvalid !== (i >= 3 && i <= 6)) begin errors++;
        $display("FAIL b2b_rvalid: cycle %0d got %b want %b", i, so_rvalid, i >= 3 && i <= 6); end
      if (i >= 3 && i <= 6) begin
        checks++; if (so_rdata !== vals[i-3]) begin errors++;
          $display("FAIL b2b_data: cycle %0d got %h want %h", i, so_rdata, vals[i-3]); end
      end
      @(negedge gpu_clk);
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    so_req = 1'b1; so_addr = 19'h00005;
    #1;
    checks++; if (so_gnt !== 1'b1) begin errors++; $display("FAIL flush_gnt0: got %b want 1", so_gnt); end
    @(negedge gpu_clk);
    so_addr = 19'h00006;
    #1;
    checks++; if (so_gnt !== 1'b1) begin errors++; $display("FAIL flush_gnt1: got %b want 1", so_gnt); end
    @(negedge gpu_clk);
    so_req = 1'b0; reset = 1'b1;
    @(negedge gpu_clk);
    reset = 1'b0;
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL flush_mem: en %b we %b addr %h wd %h want 0", mem_en, mem_we, mem_addr, mem_wdata); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (so_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++;
        $display("FAIL flush_rvalid: cycle %0d got %b want 00", k, {so_rvalid, cpu_rvalid}); end
      @(negedge gpu_clk);
    end
  endtask

  // Random traffic against a transaction-level model: priority rules decide the
  // winner, a golden memory supplies read data, returns are due LAT+1 cycles on.
  task automatic test_random(input int n);
    ret_t          q[$];
    logic [DW-1:0] gm [0:255];
    int            cyc, streak, last, win;
    bit            dr_turn, lo, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, h_so, h_cpu;
    bit            x_so, x_cpu;
    do_reset();
    for (int i = 0; i < 256; i++) gm[i] = bram[i];
    cyc = 0; streak = 0; last = 0; dr_turn = 1'b0; e_en = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wd = '0; h_so = '0; h_cpu = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge gpu_clk);
      cyc++;
      if (k > 0) begin
        checks++; if (mem_en !== e_en || (e_en && (mem_we !== e_we || mem_addr !== e_addr))) begin
          errors++; $display("FAIL rnd_cmd: cyc %0d en/we/addr %b %b %h want %b %b %h",
                             cyc, mem_en, mem_we, mem_addr, e_en, e_we, e_addr); end
        if (e_en && e_we) begin
          checks++; if (mem_wdata !== e_wd) begin errors++;
            $display("FAIL rnd_wdata: cyc %0d got %h want %h", cyc, mem_wdata, e_wd); end
        end
      end
      x_so = 1'b0; x_cpu = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        if (q[0].id == 1) begin x_so = 1'b1; h_so = q[0].d; end
        else begin x_cpu = 1'b1; h_cpu = q[0].d; end
        void'(q.pop_front());
      end
      checks++; if (so_rvalid !== x_so || cpu_rvalid !== x_cpu) begin errors++;
        $display("FAIL rnd_rvalid: cyc %0d so %b cpu %b want %b %b", cyc, so_rvalid, cpu_rvalid, x_so, x_cpu); end
      checks++; if (so_rdata !== h_so || cpu_rdata !== h_cpu) begin errors++;
        $display("FAIL rnd_rdata: cyc %0d so %h cpu %h want %h %h", cyc, so_rdata, cpu_rdata, h_so, h_cpu); end
      if (!so_req || last == 1) begin
        so_req = ($urandom % 4) != 0; so_addr = 19'($urandom % 16);
      end
      if (!cpu_req || last == 2) begin
        cpu_req = ($urandom % 3) == 0; cpu_we = $urandom % 2;
        cpu_addr = 19'($urandom % 16); cpu_wdata = DW'($urandom);
      end
      if (!dr_req || last == 3) begin
        dr_req = ($urandom % 3) == 0; dr_addr = 19'($urandom % 16); dr_wdata = DW'($urandom);
      end
      #1;
      lo = cpu_req | dr_req;
      if (so_req && !(lo && streak == LIM)) win = 1;
      else if (cpu_req && dr_req) win = dr_turn ? 3 : 2;
      else if (cpu_req) win = 2;
      else if (dr_req) win = 3;
      else win = 0;
      checks++; if (so_gnt !== (win == 1) || cpu_gnt !== (win == 2) || dr_gnt !== (win == 3)) begin
        errors++; $display("FAIL rnd_gnt: cyc %0d got s/c/d %b want winner %0d", cyc,
                           {so_gnt, cpu_gnt, dr_gnt}, win); end
      if (win == 2 || win == 3) begin streak = 0; dr_turn = (win == 2); end
      else if (!lo) streak = 0;
      else if (win == 1 && streak < LIM) streak++;
      e_en = (win != 0);
      e_we = (win == 3) || (win == 2 && cpu_we);
      e_addr = (win == 1) ? so_addr : (win == 2) ? cpu_addr : dr_addr;
      e_wd = (win == 2) ? cpu_wdata : dr_wdata;
      if (e_en && e_we) gm[e_addr[7:0]] = e_wd;
      else if (e_en) q.push_back('{cyc: cyc + 1 + LAT, id: win, d: gm[e_addr[7:0]]});
      last = win;
    end
    @(negedge gpu_clk);
    so_req = 1'b0; cpu_req = 1'b0; dr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_round_robin();
    test_starvation();
    test_back_to_back();
    test_reset_flush();
    test_random(600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
